// File: rtl/seq_divider_if.sv
// ============================================================================
// seq_divider_if : start/done handshake, operands and results of seq_divider.
// Revision 1.0
// ============================================================================
`default_nettype none

interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : unsigned restoring divider, one quotient bit per clock.
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
   parameter int WIDTH = 4
) (
   input  wire logic     clk,
   input  wire logic     reset,
   seq_divider_if.slave  bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [WIDTH:0]   part_rem, part_rem_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] dvsr, dvsr_n;
   logic [WIDTH-1:0] quot, quot_n;
   logic [WIDTH-1:0] rem, rem_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             done_q, done_n;
   logic             dbz, dbz_n;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         part_rem <= '0;
         shreg    <= '0;
         dvsr     <= '0;
         quot     <= '0;
         rem      <= '0;
         cnt      <= '0;
         done_q   <= 1'b0;
         dbz      <= 1'b0;
      end else begin
         state    <= state_n;
         part_rem <= part_rem_n;
         shreg    <= shreg_n;
         dvsr     <= dvsr_n;
         quot     <= quot_n;
         rem      <= rem_n;
         cnt      <= cnt_n;
         done_q   <= done_n;
         dbz      <= dbz_n;
      end
   end

   always_comb begin
      state_n    = state;
      part_rem_n = part_rem;
      shreg_n    = shreg;
      dvsr_n     = dvsr;
      quot_n     = quot;
      rem_n      = rem;
      cnt_n      = cnt;
      done_n     = 1'b0;
      dbz_n      = dbz;
      // part_rem[WIDTH] is always 0 after a restore, so this equals the
      // zero-extended shifted remainder.
      shifted    = {part_rem, shreg[WIDTH-1]};
      trial      = shifted - {2'b00, dvsr};

      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor != '0) begin
                  dvsr_n     = bus.divisor;
                  shreg_n    = bus.dividend;
                  part_rem_n = '0;
                  cnt_n      = '0;
                  state_n    = RUN;
               end else begin
                  quot_n = '1;
                  rem_n  = bus.dividend;
                  dbz_n  = 1'b1;
                  done_n = 1'b1;
               end
            end
         end
         RUN: begin
            if (!trial[WIDTH+1]) begin
               part_rem_n = trial[WIDTH:0];
               shreg_n    = {shreg[WIDTH-2:0], 1'b1};
            end else begin
               part_rem_n = shifted[WIDTH:0];
               shreg_n    = {shreg[WIDTH-2:0], 1'b0};
            end
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               quot_n  = shreg_n;
               rem_n   = part_rem_n[WIDTH-1:0];
               dbz_n   = 1'b0;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = done_q;
   assign bus.quotient    = quot;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dbz;
endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider : directed vectors, handshake corner cases and exhaustive
// comparison of seq_divider against a behavioural divide.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;
   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic reset;
   int   total  = 0;
   int   passed = 0;

   seq_divider_if #(.WIDTH(WIDTH)) dif ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             z;
      string            name;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic ez, input string nm);
      int   lat;
      logic busy_ok;
      @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = a;
      dif.divisor  = b;
      @(negedge clk);
      dif.start    = 1'b0;
      dif.dividend = ~a;
      dif.divisor  = ~b;
      lat     = 1;
      busy_ok = 1'b1;
      while (!dif.done && lat < 20) begin
         if (dif.busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, lat - 1, (b == 0) ? 0 : WIDTH);
      check({nm, " busy_during"}, {31'd0, busy_ok}, 1);
      check({nm, " busy_at_done"}, {31'd0, dif.busy}, 0);
      check({nm, " quotient"}, {28'd0, dif.quotient}, {28'd0, eq});
      check({nm, " remainder"}, {28'd0, dif.remainder}, {28'd0, er});
      check({nm, " div_by_zero"}, {31'd0, dif.div_by_zero}, {31'd0, ez});
      @(negedge clk);
      check({nm, " done_pulse"}, {31'd0, dif.done}, 0);
      check({nm, " q_hold"}, {28'd0, dif.quotient}, {28'd0, eq});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      logic no_done;
      logic [WIDTH-1:0] eq, er;

      vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, "13/4"};
      vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, "15/1"};
      vecs[2] = '{4'd3,  4'd10, 4'd0,  4'd3, 1'b0, "3/10"};
      vecs[3] = '{4'd0,  4'd7,  4'd0,  4'd0, 1'b0, "0/7"};
      vecs[4] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, "15/15"};
      vecs[5] = '{4'd5,  4'd0,  4'd15, 4'd5, 1'b1, "5/0"};
      vecs[6] = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0, "9/2"};

      reset        = 1'b1;
      dif.start    = 1'b0;
      dif.dividend = '0;
      dif.divisor  = '0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, dif.busy}, 0);
      check("reset done", {31'd0, dif.done}, 0);
      check("reset outputs", {23'd0, dif.quotient, dif.remainder, dif.div_by_zero}, 0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++)
         do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].name);

      // start held high; operands scrambled on every busy edge
      @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = 4'd14;
      dif.divisor  = 4'd3;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         lat = 1;
         while (!dif.done && lat < 20) begin
            dif.dividend = WIDTH'($urandom);
            dif.divisor  = WIDTH'($urandom);
            @(negedge clk);
            lat++;
         end
         eq = (k == 0) ? 4'd4 : 4'd3;
         er = 4'd2;
         check($sformatf("b2b%0d latency", k), lat - 1, WIDTH);
         check($sformatf("b2b%0d quotient", k), {28'd0, dif.quotient}, {28'd0, eq});
         check($sformatf("b2b%0d remainder", k), {28'd0, dif.remainder}, {28'd0, er});
         dif.dividend = 4'd11;
         dif.divisor  = 4'd3;
      end
      dif.start = 1'b0;

      // reset two cycles into 11/2, while the previous 11/3 result is held
      @(negedge clk);
      @(negedge clk);
      dif.start    = 1'b1;
      dif.dividend = 4'd11;
      dif.divisor  = 4'd2;
      @(negedge clk);
      dif.start = 1'b0;
      @(negedge clk);
      check("pre_reset busy", {31'd0, dif.busy}, 1);
      reset = 1'b1;
      #1;
      check("async reset busy", {31'd0, dif.busy}, 0);
      check("async reset done", {31'd0, dif.done}, 0);
      check("async reset outputs", {23'd0, dif.quotient, dif.remainder, dif.div_by_zero}, 0);
      no_done = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (dif.done !== 1'b0) no_done = 1'b0;
      end
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (dif.done !== 1'b0) no_done = 1'b0;
      end
      check("reset no done", {31'd0, no_done}, 1);
      do_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, "post_reset 11/2");

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            if (b == 0) begin
               eq = 4'hF;
               er = WIDTH'(a);
            end else begin
               eq = WIDTH'(a / b);
               er = WIDTH'(a % b);
            end
            do_div(WIDTH'(a), WIDTH'(b), eq, er, (b == 0),
                   $sformatf("exh %0d/%0d", a, b));
         end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

`default_nettype wire
